// File: rtl/addrseq_pkg.sv
// -----------------------------------------------------------------------------
// addrseq_pkg
// Shared definitions for the address sequencer slice.
//   - one-hot bit positions of the seven address-mode select strobes
//   - mode_e: decoded address mode, including hold and illegal combinations
//   - sext(): two's-complement sign extension of a narrow immediate
//   - DEFAULT_* constants used as parameter defaults
// Optional feature macro: ADDRSEQ_RSTACK_EN (return-address stack), consumed
// by address_sequencer.sv.
// -----------------------------------------------------------------------------
package addrseq_pkg;

    // Default parameter values for the sequencer and its interface
    localparam int DEFAULT_AW         = 16;
    localparam int DEFAULT_IW         = 8;
    localparam int DEFAULT_DEPTH      = 4;
    localparam int DEFAULT_RESET_ADDR = 0;

    // Bit positions of the select strobes inside the packed select vector
    localparam int SEL_RESETPC = 0;
    localparam int SEL_PCPLUSI = 1;
    localparam int SEL_PCPLUS1 = 2;
    localparam int SEL_RPLUSI  = 3;
    localparam int SEL_RPLUS0  = 4;
    localparam int SEL_CALL    = 5;
    localparam int SEL_RETURN  = 6;
    localparam int NUM_SEL     = 7;

    // Working width of sext(); every AW/IW of interest fits inside it
    localparam int SEXT_MAXW = 64;

    // Decoded address mode
    typedef enum logic [3:0] {
        MODE_HOLD,
        MODE_RESETPC,
        MODE_PCPLUSI,
        MODE_PCPLUS1,
        MODE_RPLUSI,
        MODE_RPLUS0,
        MODE_CALL,
        MODE_RETURN,
        MODE_ILLEGAL
    } mode_e;

    // Sign-extend the low 'width' bits of value to SEXT_MAXW bits. The
    // caller truncates the result to its own address width.
    function automatic logic [SEXT_MAXW-1:0] sext(input logic [SEXT_MAXW-1:0] value,
                                                  input int unsigned         width);
        logic signed [SEXT_MAXW-1:0] shifted;
        shifted = $signed(value << (SEXT_MAXW - width));
        return $unsigned(shifted >>> (SEXT_MAXW - width));
    endfunction

endpackage

// File: rtl/address_sequencer_if.sv
// -----------------------------------------------------------------------------
// address_sequencer_if
// Bundle between the controller and the address sequencer.
//   Controller -> sequencer : EnablePC, Rside[AW], Iside[IW], and the one-hot
//                             selects ResetPC, PCplusI, PCplus1, RplusI,
//                             Rplus0, Call, Return
//   Sequencer -> controller : ALout[AW] (memory address bus), PCout[AW],
//                             StackEmpty, StackFull, StackOvf, StackUnf,
//                             SelError
// modport master = controller side, modport slave = sequencer side.
// -----------------------------------------------------------------------------
interface address_sequencer_if
    import addrseq_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int IW = DEFAULT_IW
);

    logic          EnablePC;
    logic [AW-1:0] Rside;
    logic [IW-1:0] Iside;
    logic          ResetPC;
    logic          PCplusI;
    logic          PCplus1;
    logic          RplusI;
    logic          Rplus0;
    logic          Call;
    logic          Return;

    logic [AW-1:0] ALout;
    logic [AW-1:0] PCout;
    logic          StackEmpty;
    logic          StackFull;
    logic          StackOvf;
    logic          StackUnf;
    logic          SelError;

    modport master (
        output EnablePC, Rside, Iside,
        output ResetPC, PCplusI, PCplus1, RplusI, Rplus0, Call, Return,
        input  ALout, PCout, StackEmpty, StackFull, StackOvf, StackUnf, SelError
    );

    modport slave (
        input  EnablePC, Rside, Iside,
        input  ResetPC, PCplusI, PCplus1, RplusI, Rplus0, Call, Return,
        output ALout, PCout, StackEmpty, StackFull, StackOvf, StackUnf, SelError
    );

endinterface

// File: rtl/addrseq_rstack.sv
// -----------------------------------------------------------------------------
// addrseq_rstack
// Circular return-address LIFO. Pushing onto a full stack overwrites the
// oldest entry and keeps it full; popping an empty stack changes nothing.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clear_i      : empty the stack and clear the sticky flags
//   push_i       : push pushData_i[AW]
//   pop_i        : pop the top entry
//   top_o[AW]    : current top entry (meaningless while empty_o is high)
//   empty_o      : no valid entries
//   full_o       : DEPTH valid entries
//   ovf_o, unf_o : sticky overflow / underflow
// -----------------------------------------------------------------------------
module addrseq_rstack
    import addrseq_pkg::*;
#(
    parameter int AW    = DEFAULT_AW,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] pushData_i,
    output logic [AW-1:0] top_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          ovf_o,
    output logic          unf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] topPtr_q, topPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [PW-1:0] pushPtr;

    assign pushPtr = topPtr_q + PW'(1);
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign top_o   = mem_q[topPtr_q];
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

    // Pointer/count/flag update. Clear wins over push and pop. A push on a
    // full stack advances the pointer anyway, so the new top lands on the
    // oldest slot, while the count saturates at DEPTH.
    always_comb begin
        topPtr_d = topPtr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (clear_i) begin
            topPtr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else if (push_i) begin
            topPtr_d = pushPtr;
            if (full_o) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (pop_i) begin
            if (empty_o) begin
                unf_d = 1'b1;
            end else begin
                topPtr_d = topPtr_q - PW'(1);
                count_d  = count_q - CW'(1);
            end
        end
    end

    // Control state register; reset leaves the stack empty with flags clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            topPtr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            topPtr_q <= topPtr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Entry storage needs no reset: the count alone decides validity
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[pushPtr] <= pushData_i;
        end
    end

endmodule

// File: rtl/address_sequencer.sv
// -----------------------------------------------------------------------------
// address_sequencer
// Program counter and next-address generation for the Sayeh-class datapath.
// Ports:
//   clk           : clock, rising edge
//   ExternalReset : asynchronous active-high reset
//   bus           : address_sequencer_if.slave (EnablePC, Rside, Iside, the
//                   seven one-hot selects; ALout, PCout, stack flags,
//                   SelError)
// ALout is the combinational next address; PC takes it on EnablePC edges.
// Two or more selects at once hold the PC and pulse SelError after a
// committed edge.
// Optional feature: define ADDRSEQ_RSTACK_EN to build the return-address
// stack behind Call/Return. Without it, Call/Return are illegal selects and
// the stack flags are tied to empty/clear.
// -----------------------------------------------------------------------------
module address_sequencer
    import addrseq_pkg::*;
#(
    parameter int            AW         = DEFAULT_AW,
    parameter int            IW         = DEFAULT_IW,
    parameter int            DEPTH      = DEFAULT_DEPTH,
    parameter logic [AW-1:0] RESET_ADDR = AW'(DEFAULT_RESET_ADDR)
) (
    input logic                clk,
    input logic                ExternalReset,
    address_sequencer_if.slave bus
);

    // Reject parameter sets the datapath cannot represent
    if (IW > AW) begin : gIwCheck
        $error("address_sequencer: IW must not exceed AW");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gDepthCheck
        $error("address_sequencer: DEPTH must be a power of two >= 2");
    end

    logic [AW-1:0]      pc_q, pc_d;
    logic               selErr_q, selErr_d;
    logic [NUM_SEL-1:0] selVec;
    mode_e              selMode;
    logic [AW-1:0]      sextI;
    logic [AW-1:0]      pcPlus1;
    logic [AW-1:0]      alOut;
    logic               commit;
    logic [AW-1:0]      stackTop;
    logic               stackEmpty;
    logic               stackFull;
    logic               stackOvf;
    logic               stackUnf;

    assign selVec = {bus.Return, bus.Call, bus.Rplus0, bus.RplusI,
                     bus.PCplus1, bus.PCplusI, bus.ResetPC};

    assign sextI   = AW'(sext(SEXT_MAXW'(bus.Iside), IW));
    assign pcPlus1 = pc_q + AW'(1);
    assign commit  = bus.EnablePC;

    // Select decode. More than one strobe is illegal; without the return
    // stack Call and Return have nothing to act on and are illegal too.
    always_comb begin
        selMode = MODE_HOLD;
        if ($countones(selVec) > 1) begin
            selMode = MODE_ILLEGAL;
        end else if (selVec[SEL_RESETPC]) begin
            selMode = MODE_RESETPC;
        end else if (selVec[SEL_PCPLUSI]) begin
            selMode = MODE_PCPLUSI;
        end else if (selVec[SEL_PCPLUS1]) begin
            selMode = MODE_PCPLUS1;
        end else if (selVec[SEL_RPLUSI]) begin
            selMode = MODE_RPLUSI;
        end else if (selVec[SEL_RPLUS0]) begin
            selMode = MODE_RPLUS0;
        end else if (selVec[SEL_CALL]) begin
            selMode = MODE_CALL;
        end else if (selVec[SEL_RETURN]) begin
            selMode = MODE_RETURN;
        end
`ifndef ADDRSEQ_RSTACK_EN
        if (selMode == MODE_CALL || selMode == MODE_RETURN) begin
            selMode = MODE_ILLEGAL;
        end
`endif
    end

    // Next-address mux; hold and illegal both present the current PC
    always_comb begin
        alOut = pc_q;
        case (selMode)
            MODE_RESETPC: alOut = RESET_ADDR;
            MODE_PCPLUSI: alOut = pc_q + sextI;
            MODE_PCPLUS1: alOut = pcPlus1;
            MODE_RPLUSI:  alOut = bus.Rside + sextI;
            MODE_RPLUS0:  alOut = bus.Rside;
            MODE_CALL:    alOut = pc_q + sextI;
            MODE_RETURN:  alOut = stackEmpty ? pcPlus1 : stackTop;
            default:      alOut = pc_q;
        endcase
    end

    // PC and error-pulse next state: only committed cycles move anything
    always_comb begin
        pc_d     = pc_q;
        selErr_d = 1'b0;
        if (commit) begin
            pc_d     = alOut;
            selErr_d = (selMode == MODE_ILLEGAL);
        end
    end

    // PC and SelError registers
    always_ff @(posedge clk or posedge ExternalReset) begin
        if (ExternalReset) begin
            pc_q     <= RESET_ADDR;
            selErr_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            selErr_q <= selErr_d;
        end
    end

`ifdef ADDRSEQ_RSTACK_EN
    // Call pushes the return address PC+1; ResetPC wipes the stack
    addrseq_rstack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) uRstack (
        .clk        (clk),
        .rst        (ExternalReset),
        .clear_i    (commit && (selMode == MODE_RESETPC)),
        .push_i     (commit && (selMode == MODE_CALL)),
        .pop_i      (commit && (selMode == MODE_RETURN)),
        .pushData_i (pcPlus1),
        .top_o      (stackTop),
        .empty_o    (stackEmpty),
        .full_o     (stackFull),
        .ovf_o      (stackOvf),
        .unf_o      (stackUnf)
    );
`else
    assign stackTop   = '0;
    assign stackEmpty = 1'b1;
    assign stackFull  = 1'b0;
    assign stackOvf   = 1'b0;
    assign stackUnf   = 1'b0;
`endif

    assign bus.ALout      = alOut;
    assign bus.PCout      = pc_q;
    assign bus.SelError   = selErr_q;
    assign bus.StackEmpty = stackEmpty;
    assign bus.StackFull  = stackFull;
    assign bus.StackOvf   = stackOvf;
    assign bus.StackUnf   = stackUnf;

endmodule

// File: tb/tb_address_sequencer.sv
// -----------------------------------------------------------------------------
// tb_address_sequencer
// Directed bench for address_sequencer (AW=16, IW=8, DEPTH=4, RESET_ADDR=0).
// Inputs change one time unit after a rising edge; outputs are sampled then
// too, so combinational ALout reflects the new selects and PCout reflects
// the edge just taken. Stack-specific steps follow ADDRSEQ_RSTACK_EN.
// -----------------------------------------------------------------------------
module tb_address_sequencer;
    import addrseq_pkg::*;

    localparam logic [6:0] S_NONE    = 7'd0;
    localparam logic [6:0] S_RESETPC = 7'(1) << SEL_RESETPC;
    localparam logic [6:0] S_PCPLUSI = 7'(1) << SEL_PCPLUSI;
    localparam logic [6:0] S_PCPLUS1 = 7'(1) << SEL_PCPLUS1;
    localparam logic [6:0] S_RPLUSI  = 7'(1) << SEL_RPLUSI;
    localparam logic [6:0] S_RPLUS0  = 7'(1) << SEL_RPLUS0;
    localparam logic [6:0] S_CALL    = 7'(1) << SEL_CALL;
    localparam logic [6:0] S_RETURN  = 7'(1) << SEL_RETURN;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    address_sequencer_if #(.AW(16), .IW(8)) bus ();

    address_sequencer #(
        .AW         (16),
        .IW         (8),
        .DEPTH      (4),
        .RESET_ADDR (16'h0000)
    ) dut (
        .clk           (clk),
        .ExternalReset (rst),
        .bus           (bus)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one set of controller inputs
    task automatic applyStimulus(input logic [6:0] sel, input logic en,
                                 input logic [15:0] r, input logic [7:0] imm);
        bus.ResetPC  = sel[SEL_RESETPC];
        bus.PCplusI  = sel[SEL_PCPLUSI];
        bus.PCplus1  = sel[SEL_PCPLUS1];
        bus.RplusI   = sel[SEL_RPLUSI];
        bus.Rplus0   = sel[SEL_RPLUS0];
        bus.Call     = sel[SEL_CALL];
        bus.Return   = sel[SEL_RETURN];
        bus.EnablePC = en;
        bus.Rside    = r;
        bus.Iside    = imm;
    endtask

    // One comparison against a hand-computed value
    task automatic checkOutput(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load PC with an arbitrary value through Rplus0
    task automatic loadPc(input logic [15:0] value);
        applyStimulus(S_RPLUS0, 1'b1, value, 8'h00);
        tick();
    endtask

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(S_NONE, 1'b0, 16'h0000, 8'h00);
        #1;
        checkOutput("rst_pcout",   bus.PCout, 16'h0000);
        checkOutput("rst_alout",   bus.ALout, 16'h0000);
        checkOutput("rst_empty",   16'(bus.StackEmpty), 16'd1);
        checkOutput("rst_full",    16'(bus.StackFull),  16'd0);
        checkOutput("rst_ovf",     16'(bus.StackOvf),   16'd0);
        checkOutput("rst_unf",     16'(bus.StackUnf),   16'd0);
        checkOutput("rst_selerr",  16'(bus.SelError),   16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch
        applyStimulus(S_PCPLUS1, 1'b1, 16'h0000, 8'h00);
        #1;
        checkOutput("inc_alout", bus.ALout, 16'h0001);
        tick();
        checkOutput("inc_pc1", bus.PCout, 16'h0001);
        tick();
        checkOutput("inc_pc2", bus.PCout, 16'h0002);
        tick();
        checkOutput("inc_pc3", bus.PCout, 16'h0003);

        // Negative relative offset, and hold while EnablePC is low
        loadPc(16'h0010);
        checkOutput("rplus0_pc", bus.PCout, 16'h0010);
        applyStimulus(S_PCPLUSI, 1'b0, 16'h0000, 8'hFE);
        #1;
        checkOutput("pcplusi_neg", bus.ALout, 16'h000E);
        tick();
        checkOutput("hold_pc", bus.PCout, 16'h0010);

        // Register-relative with positive and negative immediates
        applyStimulus(S_RPLUSI, 1'b0, 16'h1000, 8'h7F);
        #1;
        checkOutput("rplusi_pos", bus.ALout, 16'h107F);
        applyStimulus(S_RPLUSI, 1'b0, 16'h1000, 8'h80);
        #1;
        checkOutput("rplusi_neg", bus.ALout, 16'h0F80);

        // Wrap-around at the top of the address space
        loadPc(16'hFFFF);
        applyStimulus(S_PCPLUS1, 1'b1, 16'h0000, 8'h00);
        #1;
        checkOutput("wrap_alout", bus.ALout, 16'h0000);
        tick();
        checkOutput("wrap_pc", bus.PCout, 16'h0000);

        // ResetPC select and plain hold
        loadPc(16'h1234);
        applyStimulus(S_RESETPC, 1'b0, 16'h0000, 8'h00);
        #1;
        checkOutput("resetpc_alout", bus.ALout, 16'h0000);
        applyStimulus(S_NONE, 1'b1, 16'h5555, 8'h11);
        #1;
        checkOutput("nosel_alout", bus.ALout, 16'h1234);
        tick();
        checkOutput("nosel_pc", bus.PCout, 16'h1234);
        applyStimulus(S_RESETPC, 1'b1, 16'h0000, 8'h00);
        tick();
        checkOutput("resetpc_pc", bus.PCout, 16'h0000);

        // Illegal select combinations
        loadPc(16'h0050);
        applyStimulus(S_PCPLUS1 | S_RPLUSI, 1'b1, 16'h0300, 8'h04);
        #1;
        checkOutput("illegal_alout", bus.ALout, 16'h0050);
        checkOutput("illegal_noerr_yet", 16'(bus.SelError), 16'd0);
        tick();
        checkOutput("illegal_pc", bus.PCout, 16'h0050);
        checkOutput("illegal_pulse", 16'(bus.SelError), 16'd1);
        applyStimulus(S_NONE, 1'b0, 16'h0000, 8'h00);
        tick();
        checkOutput("illegal_pulse_end", 16'(bus.SelError), 16'd0);
        applyStimulus(S_PCPLUS1 | S_RPLUSI, 1'b0, 16'h0300, 8'h04);
        tick();
        checkOutput("illegal_noen", 16'(bus.SelError), 16'd0);
        checkOutput("illegal_noen_pc", bus.PCout, 16'h0050);

`ifdef ADDRSEQ_RSTACK_EN
        // Call then Return back to back
        loadPc(16'h0100);
        applyStimulus(S_CALL, 1'b1, 16'h0000, 8'h20);
        #1;
        checkOutput("call_alout", bus.ALout, 16'h0120);
        tick();
        checkOutput("call_pc", bus.PCout, 16'h0120);
        checkOutput("call_nonempty", 16'(bus.StackEmpty), 16'd0);
        applyStimulus(S_RETURN, 1'b1, 16'h0000, 8'h00);
        #1;
        checkOutput("ret_alout", bus.ALout, 16'h0101);
        tick();
        checkOutput("ret_pc", bus.PCout, 16'h0101);
        checkOutput("ret_empty", 16'(bus.StackEmpty), 16'd1);

        // Fill past DEPTH from PC 0: pushes 1..5, oldest (1) overwritten
        applyStimulus(S_RESETPC, 1'b1, 16'h0000, 8'h00);
        tick();
        applyStimulus(S_CALL, 1'b1, 16'h0000, 8'h01);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("fill_pc%0d", i), bus.PCout, 16'(i));
        end
        checkOutput("four_full", 16'(bus.StackFull), 16'd1);
        checkOutput("four_noovf", 16'(bus.StackOvf), 16'd0);
        tick();
        checkOutput("fill_pc5", bus.PCout, 16'h0005);
        checkOutput("five_full", 16'(bus.StackFull), 16'd1);
        checkOutput("five_ovf", 16'(bus.StackOvf), 16'd1);

        applyStimulus(S_RETURN, 1'b1, 16'h0000, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("pop_pc%0d", i), bus.PCout, 16'(5 - i));
        end
        checkOutput("pop_empty", 16'(bus.StackEmpty), 16'd1);
        checkOutput("pop_nounf", 16'(bus.StackUnf), 16'd0);
        #1;
        checkOutput("unf_alout", bus.ALout, 16'h0003);
        tick();
        checkOutput("unf_pc", bus.PCout, 16'h0003);
        checkOutput("unf_flag", 16'(bus.StackUnf), 16'd1);
        checkOutput("unf_ovf_sticky", 16'(bus.StackOvf), 16'd1);

        // Two Calls deep, then reset between edges
        applyStimulus(S_CALL, 1'b1, 16'h0000, 8'h10);
        tick();
        tick();
        checkOutput("deep_pc", bus.PCout, 16'h0023);
        checkOutput("deep_unf_sticky", 16'(bus.StackUnf), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_pc", bus.PCout, 16'h0000);
        checkOutput("arst_empty", 16'(bus.StackEmpty), 16'd1);
        checkOutput("arst_ovf", 16'(bus.StackOvf), 16'd0);
        checkOutput("arst_unf", 16'(bus.StackUnf), 16'd0);
        checkOutput("arst_full", 16'(bus.StackFull), 16'd0);
`else
        // Without the stack, Call and Return behave as illegal selects
        applyStimulus(S_CALL, 1'b1, 16'h0000, 8'h20);
        #1;
        checkOutput("call_alout", bus.ALout, 16'h0050);
        tick();
        checkOutput("call_pc", bus.PCout, 16'h0050);
        checkOutput("call_selerr", 16'(bus.SelError), 16'd1);
        applyStimulus(S_RETURN, 1'b1, 16'h0000, 8'h00);
        tick();
        checkOutput("ret_pc", bus.PCout, 16'h0050);
        checkOutput("ret_selerr", 16'(bus.SelError), 16'd1);
        checkOutput("tie_empty", 16'(bus.StackEmpty), 16'd1);
        checkOutput("tie_full", 16'(bus.StackFull), 16'd0);
        checkOutput("tie_ovf", 16'(bus.StackOvf), 16'd0);
        checkOutput("tie_unf", 16'(bus.StackUnf), 16'd0);

        // Reset between edges with EnablePC still high
        loadPc(16'h0222);
        applyStimulus(S_PCPLUS1, 1'b1, 16'h0000, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_pc", bus.PCout, 16'h0000);
        checkOutput("arst_alout", bus.ALout, 16'h0001);
`endif
        checkOutput("arst_selerr", 16'(bus.SelError), 16'd0);
        @(negedge clk);
        applyStimulus(S_NONE, 1'b0, 16'h0000, 8'h00);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_alout", bus.ALout, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
